// File: rtl/bcd_field_counter.sv
// Single-clock BCD time-field counter (seconds/minutes/hours), chainable via tick_in/carry_out.
// Optional auto-repeat of set-mode stepping is compiled in with `define BCD_FIELD_AUTOREPEAT_EN.
module bcd_field_counter #(
    parameter int MODULUS       = 60,
    parameter int MIN_VALUE     = 0,
    parameter int DIGITS        = 2,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 250
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_in,
    input  logic                  set_ena,
    input  logic                  up,
    input  logic                  down,
    output logic [4*DIGITS-1:0]   BCD_out,
    output logic                  carry_out,
    output logic                  at_max
);

    localparam int MAX_VALUE = MIN_VALUE + MODULUS - 1;
    localparam int VW_RAW    = $clog2(MIN_VALUE + MODULUS);
    localparam int VW        = (VW_RAW < 1) ? 1 : VW_RAW;
    localparam logic [VW-1:0] MIN_V = VW'(MIN_VALUE);
    localparam logic [VW-1:0] MAX_V = VW'(MAX_VALUE);

    // Elaboration-time parameter sanity checks
    if (MODULUS < 1 || MIN_VALUE < 0 || MAX_VALUE >= 10**DIGITS) begin : g_bad_range
        $error("bcd_field_counter: range does not fit in DIGITS BCD digits");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("bcd_field_counter: repeat timing must be at least one cycle");
    end

    function automatic logic [VW-1:0] inc_wrap(input logic [VW-1:0] v);
        return (v == MAX_V) ? MIN_V : v + VW'(1);
    endfunction

    function automatic logic [VW-1:0] dec_wrap(input logic [VW-1:0] v);
        return (v == MIN_V) ? MAX_V : v - VW'(1);
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input logic [VW-1:0] v);
        logic [4*DIGITS-1:0] res;
        int unsigned         rem;
        res = {(4*DIGITS){1'b0}};
        rem = 32'(v);
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(rem % 32'd10);
            rem           = rem / 32'd10;
        end
        return res;
    endfunction

    logic [VW-1:0] value_q, value_d;
    logic          up_q, down_q;
    logic          up_edge_s, down_edge_s;
    logic          step_up_s, step_dn_s;

    assign up_edge_s   = up & ~up_q;
    assign down_edge_s = down & ~down_q;

`ifdef BCD_FIELD_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    // hold_q counts cycles since the last step; zero means no repeat is armed
    logic [HW-1:0] hold_q, hold_d;
    logic          rpt_q, rpt_d;
    logic          rpt_fire_s;

    // Hold counter next state and repeat-step generation
    always_comb begin
        hold_d     = {HW{1'b0}};
        rpt_d      = 1'b0;
        rpt_fire_s = 1'b0;
        if (set_ena && (up ^ down)) begin
            if (up_edge_s || down_edge_s) begin
                hold_d = HW'(1);
                rpt_d  = 1'b0;
            end else if (hold_q != {HW{1'b0}}) begin
                if (!rpt_q && hold_q == HW'(REPEAT_DELAY)) begin
                    rpt_fire_s = 1'b1;
                    hold_d     = HW'(1);
                    rpt_d      = 1'b1;
                end else if (rpt_q && hold_q == HW'(REPEAT_PERIOD)) begin
                    rpt_fire_s = 1'b1;
                    hold_d     = HW'(1);
                    rpt_d      = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                    rpt_d  = rpt_q;
                end
            end else begin
                hold_d = {HW{1'b0}};
                rpt_d  = 1'b0;
            end
        end else begin
            hold_d = {HW{1'b0}};
            rpt_d  = 1'b0;
        end
    end

    // Hold counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= {HW{1'b0}};
            rpt_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rpt_q  <= rpt_d;
        end
    end

    assign step_up_s = up_edge_s   | (rpt_fire_s & up);
    assign step_dn_s = down_edge_s | (rpt_fire_s & down);
`else
    assign step_up_s = up_edge_s;
    assign step_dn_s = down_edge_s;
`endif

    // Value next state: tick counting in run mode, button stepping in set mode
    always_comb begin
        value_d = value_q;
        if (!set_ena) begin
            if (tick_in) begin
                value_d = inc_wrap(value_q);
            end else begin
                value_d = value_q;
            end
        end else if (step_up_s && !step_dn_s) begin
            value_d = inc_wrap(value_q);
        end else if (step_dn_s && !step_up_s) begin
            value_d = dec_wrap(value_q);
        end else begin
            value_d = value_q;
        end
    end

    // Value and button-edge registers
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= MIN_V;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            up_q    <= up;
            down_q  <= down;
        end
    end

    // Carry is combinational so a whole chain rolls over in the tick cycle
    assign BCD_out   = to_bcd(value_q);
    assign at_max    = (value_q == MAX_V);
    assign carry_out = tick_in & at_max & ~set_ena;

endmodule
